// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding, instruction field constants, mux-select
// encodings, PSR bit positions and condition codes for control_fsm.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_LATCH    = 4'd2,
        S_DECODE   = 4'd3,
        S_EXEC_R   = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB       = 4'd6,
        S_MOVI     = 4'd7,
        S_LD_ADDR  = 4'd8,
        S_LD_LATCH = 4'd9,
        S_LD_WB    = 4'd10,
        S_ST       = 4'd11,
        S_BR       = 4'd12,
        S_JMP      = 4'd13,
        S_JAL      = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_t;

    // Primary opcodes
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;

    // Extensions
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // Mux selects
    localparam logic [1:0] MEM_S_RSRC  = 2'd0;
    localparam logic [1:0] MEM_S_PC    = 2'd1;
    localparam logic [1:0] WD_S_IMM    = 2'd0;
    localparam logic [1:0] WD_S_RSRC   = 2'd1;
    localparam logic [1:0] WD_S_MEM    = 2'd2;
    localparam logic [1:0] WD_S_ALU    = 2'd3;
    localparam logic [1:0] ALUA_S_RSRC = 2'd0;
    localparam logic [1:0] ALUA_S_PC   = 2'd1;
    localparam logic [1:0] ALUA_S_IMM  = 2'd2;
    localparam logic [1:0] ALUB_S_RDEST = 2'd0;
    localparam logic [1:0] ALUB_S_IMM   = 2'd1;
    localparam logic [1:0] ALUB_S_ONE   = 2'd2;
    localparam logic [1:0] ALUB_S_ZERO  = 2'd3;

    // PSR bit positions
    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    // Condition codes carried in the Rdest field
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_LO = 4'b0100;
    localparam logic [3:0] CC_NL = 4'b0101;
    localparam logic [3:0] CC_MI = 4'b0110;
    localparam logic [3:0] CC_PL = 4'b0111;
    localparam logic [3:0] CC_AL = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    // Registered control word; pc_cond marks states whose PC_EN follows the condition
    typedef struct packed {
        logic       pc_s;
        logic       mem_data_s;
        logic       instr_en;
        logic       alu_out_en;
        logic       mem_reg_en;
        logic       pc_en;
        logic       pc_cond;
        logic       psr_en;
        logic       se_on;
        logic       reg_wr;
        logic       mem_we;
        logic [1:0] mem_s;
        logic [1:0] wd_s;
        logic [1:0] alua_s;
        logic [1:0] alub_s;
    } ctrl_t;

    // Logical immediates and MOVI take a zero-extended immediate
    function automatic logic zero_ext_op(input logic [3:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_MOVI);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational branch/jump condition test on the PSR flags.
module cond_eval
    import ctrl_pkg::*;
#(
    parameter int PSRL = 5
) (
    input  logic [3:0]      cond,
    input  logic [PSRL-1:0] psr,
    output logic            cond_true
);

    // The F flag takes part in no condition; named so it is knowingly dropped
    logic unused_psr_f;
    assign unused_psr_f = psr[PSR_F];

    // Select the flag test named by the condition code
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            CC_EQ:   cond_true = psr[PSR_Z];
            CC_NE:   cond_true = ~psr[PSR_Z];
            CC_CS:   cond_true = psr[PSR_C];
            CC_CC:   cond_true = ~psr[PSR_C];
            CC_LO:   cond_true = psr[PSR_L];
            CC_NL:   cond_true = ~psr[PSR_L];
            CC_MI:   cond_true = psr[PSR_N];
            CC_PL:   cond_true = ~psr[PSR_N];
            CC_AL:   cond_true = 1'b1;
            CC_NV:   cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle control unit for the 16-bit CPU.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to make an illegal opcode
// lock the FSM in ILLEGAL with the sticky illegal_op flag raised; otherwise
// ILLEGAL is a one-cycle NOP and illegal_op is tied low.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int REG_ADD = 4,
    parameter int PSRL    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_ADD-1:0] OP_CODE,
    input  logic [REG_ADD-1:0] OP_EXT,
    input  logic [REG_ADD-1:0] Rdest_addr,
    input  logic [PSRL-1:0]    PSR_OUT,
    output logic               PC_S,
    output logic               MEM_DATA_S,
    output logic               INSTR_EN,
    output logic               ALU_OUT_EN,
    output logic               MEM_REG_EN,
    output logic               PC_EN,
    output logic               PSR_EN,
    output logic               SE_SIGN,
    output logic               REG_WR,
    output logic               MEM_WE,
    output logic [1:0]         MEM_S,
    output logic [1:0]         WD_S,
    output logic [1:0]         ALUA_S,
    output logic [1:0]         ALUB_S,
    output logic               illegal_op
);

    state_t     state;
    state_t     nxt;
    ctrl_t      ctl;
    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] cc;
    logic       cond_true;

    assign op  = 4'(OP_CODE);
    assign ext = 4'(OP_EXT);
    assign cc  = 4'(Rdest_addr);

    cond_eval #(.PSRL(PSRL)) u_cond (
        .cond      (cc),
        .psr       (PSR_OUT),
        .cond_true (cond_true)
    );

    // Control word for a state; registered together with the state itself
    function automatic ctrl_t state_ctrl(input state_t st);
        ctrl_t c;
        c       = '0;
        c.mem_s = MEM_S_PC;
        c.se_on = 1'b1;
        case (st)
            S_RST: begin
                c.mem_s = MEM_S_RSRC;
                c.se_on = 1'b0;
            end
            S_FETCH: begin
                c.alua_s = ALUA_S_PC;
                c.alub_s = ALUB_S_ONE;
                c.pc_s   = 1'b1;
                c.pc_en  = 1'b1;
            end
            S_LATCH:  c.instr_en = 1'b1;
            S_EXEC_R: begin
                c.alua_s     = ALUA_S_RSRC;
                c.alub_s     = ALUB_S_RDEST;
                c.alu_out_en = 1'b1;
                c.psr_en     = 1'b1;
            end
            S_EXEC_I: begin
                c.alua_s     = ALUA_S_IMM;
                c.alub_s     = ALUB_S_RDEST;
                c.alu_out_en = 1'b1;
                c.psr_en     = 1'b1;
            end
            S_WB, S_MOVI, S_LD_WB: begin
                c.reg_wr = 1'b1;
                c.wd_s   = (st == S_WB) ? WD_S_ALU : ((st == S_MOVI) ? WD_S_IMM : WD_S_MEM);
            end
            S_LD_ADDR: c.mem_s = MEM_S_RSRC;
            S_LD_LATCH: begin
                c.mem_s      = MEM_S_RSRC;
                c.mem_reg_en = 1'b1;
            end
            S_ST: begin
                c.mem_s      = MEM_S_RSRC;
                c.mem_data_s = 1'b0;
                c.mem_we     = 1'b1;
            end
            S_BR: begin
                c.alua_s  = ALUA_S_PC;
                c.alub_s  = ALUB_S_IMM;
                c.pc_s    = 1'b1;
                c.pc_cond = 1'b1;
            end
            S_JMP: begin
                c.pc_s    = 1'b0;
                c.pc_cond = 1'b1;
            end
            S_JAL: begin
                c.alua_s     = ALUA_S_PC;
                c.alub_s     = ALUB_S_ZERO;
                c.alu_out_en = 1'b1;
                c.pc_s       = 1'b0;
                c.pc_en      = 1'b1;
            end
            S_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                c.mem_s = MEM_S_RSRC;
                c.se_on = 1'b0;
`else
                c.se_on = 1'b1;
`endif
            end
            default: c.se_on = 1'b1;
        endcase
        return c;
    endfunction

    // Next-state selection, including opcode decode in DECODE
    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_RST:    nxt = S_FETCH;
            S_FETCH:  nxt = S_LATCH;
            S_LATCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:                                        nxt = S_EXEC_R;
                    OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI: nxt = S_EXEC_I;
                    OP_MOVI:                                         nxt = S_MOVI;
                    OP_BCOND:                                        nxt = S_BR;
                    OP_MEM: begin
                        case (ext)
                            EXT_LOAD:  nxt = S_LD_ADDR;
                            EXT_STOR:  nxt = S_ST;
                            EXT_JAL:   nxt = S_JAL;
                            EXT_JCOND: nxt = S_JMP;
                            default:   nxt = S_ILLEGAL;
                        endcase
                    end
                    default: nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   nxt = (ext == EXT_CMP) ? S_FETCH : S_WB;
            S_EXEC_I:   nxt = (op == OP_CMPI) ? S_FETCH : S_WB;
            S_JAL:      nxt = S_WB;
            S_LD_ADDR:  nxt = S_LD_LATCH;
            S_LD_LATCH: nxt = S_LD_WB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL:  nxt = S_ILLEGAL;
`else
            S_ILLEGAL:  nxt = S_FETCH;
`endif
            default:    nxt = S_FETCH;
        endcase
    end

    // State register with the control word for the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RST;
            ctl   <= '0;
        end else begin
            state <= nxt;
            ctl   <= state_ctrl(nxt);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_flag;

    // Sticky flag raised on entry to the trap state, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_flag <= 1'b0;
        end else if (nxt == S_ILLEGAL) begin
            illegal_flag <= 1'b1;
        end else begin
            illegal_flag <= illegal_flag;
        end
    end

    assign illegal_op = illegal_flag;
`else
    assign illegal_op = 1'b0;
`endif

    // BR/JMP gate PC_EN with the condition evaluated on the live PSR
    assign PC_EN      = ctl.pc_en | (ctl.pc_cond & cond_true);
    assign SE_SIGN    = ctl.se_on & ~zero_ext_op(op);
    assign PC_S       = ctl.pc_s;
    assign MEM_DATA_S = ctl.mem_data_s;
    assign INSTR_EN   = ctl.instr_en;
    assign ALU_OUT_EN = ctl.alu_out_en;
    assign MEM_REG_EN = ctl.mem_reg_en;
    assign PSR_EN     = ctl.psr_en;
    assign REG_WR     = ctl.reg_wr;
    assign MEM_WE     = ctl.mem_we;
    assign MEM_S      = ctl.mem_s;
    assign WD_S       = ctl.wd_s;
    assign ALUA_S     = ctl.alua_s;
    assign ALUB_S     = ctl.alub_s;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed self-checking bench for control_fsm. An
// instruction-level model expands each instruction into its expected
// per-cycle outputs; one compare process checks them every cycle.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] OP_CODE, OP_EXT, Rdest_addr;
    logic [4:0] PSR_OUT;
    logic       PC_S, MEM_DATA_S, INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN;
    logic       PSR_EN, SE_SIGN, REG_WR, MEM_WE, illegal_op;
    logic [1:0] MEM_S, WD_S, ALUA_S, ALUB_S;

    int n_tests = 0;
    int n_fail  = 0;

    control_fsm #(.REG_ADD(4), .PSRL(5)) dut (
        .clk(clk), .reset(reset), .OP_CODE(OP_CODE), .OP_EXT(OP_EXT),
        .Rdest_addr(Rdest_addr), .PSR_OUT(PSR_OUT), .PC_S(PC_S),
        .MEM_DATA_S(MEM_DATA_S), .INSTR_EN(INSTR_EN), .ALU_OUT_EN(ALU_OUT_EN),
        .MEM_REG_EN(MEM_REG_EN), .PC_EN(PC_EN), .PSR_EN(PSR_EN),
        .SE_SIGN(SE_SIGN), .REG_WR(REG_WR), .MEM_WE(MEM_WE), .MEM_S(MEM_S),
        .WD_S(WD_S), .ALUA_S(ALUA_S), .ALUB_S(ALUB_S), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Expected output vector; se_on means "sign extension is live in this cycle"
    typedef struct packed {
        logic       pc_s, mem_data_s, instr_en, alu_out_en, mem_reg_en, pc_en;
        logic       psr_en, reg_wr, mem_we, illegal_op, se_on;
        logic [1:0] mem_s, wd_s, alua_s, alub_s;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    exp_t req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t dut_vec();
        exp_t a;
        a.pc_s = PC_S; a.mem_data_s = MEM_DATA_S; a.instr_en = INSTR_EN;
        a.alu_out_en = ALU_OUT_EN; a.mem_reg_en = MEM_REG_EN; a.pc_en = PC_EN;
        a.psr_en = PSR_EN; a.reg_wr = REG_WR; a.mem_we = MEM_WE;
        a.illegal_op = illegal_op; a.se_on = SE_SIGN; a.mem_s = MEM_S;
        a.wd_s = WD_S; a.alua_s = ALUA_S; a.alub_s = ALUB_S;
        return a;
    endfunction

    // Zero extension for ANDI/ORI/XORI/MOVI, sign extension otherwise
    function automatic logic model_se(input logic on, input logic [3:0] op);
        return on && !(op inside {4'd1, 4'd2, 4'd3, 4'd13});
    endfunction

    // Conditions: pairs (flag, !flag) in order Z, C, L, N; 1110 always; rest never
    function automatic logic model_cond(input logic [3:0] cc, input logic [4:0] psr);
        logic [3:0] flags;
        flags = {psr[4], psr[1], psr[0], psr[3]};
        if (cc == 4'b1110) return 1'b1;
        if (cc[3]) return 1'b0;
        return flags[cc[2:1]] ^ cc[0];
    endfunction

    function automatic exp_t ex_base();
        exp_t e;
        e = '0;
        e.mem_s = 2'd1;
        e.se_on = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_fetch();
        exp_t e;
        e = ex_base();
        e.alua_s = 2'd1; e.alub_s = 2'd2; e.pc_s = 1'b1; e.pc_en = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_wr(input logic [1:0] wd);
        exp_t e;
        e = ex_base();
        e.wd_s = wd; e.reg_wr = 1'b1;
        return e;
    endfunction

    // Expand one instruction (after its FETCH) into expected cycles; returns CPI
    function automatic int model_instr(input logic [3:0] op, input logic [3:0] ext,
                                       input logic [3:0] cc, input logic [4:0] psr);
        exp_t e;
        int   n;
        n = 3;
        e = ex_base(); e.instr_en = 1'b1; exp_q.push_back(e);
        exp_q.push_back(ex_base());
        e = ex_base();
        if (op == 4'd0 || op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11}) begin
            e.alua_s = (op == 4'd0) ? 2'd0 : 2'd2;
            e.alu_out_en = 1'b1; e.psr_en = 1'b1;
            exp_q.push_back(e); n++;
            if (!((op == 4'd0 && ext == 4'b1011) || op == 4'd11)) begin
                exp_q.push_back(ex_wr(2'd3)); n++;
            end
        end else if (op == 4'd13) begin
            exp_q.push_back(ex_wr(2'd0)); n++;
        end else if (op == 4'd12) begin
            e.alua_s = 2'd1; e.alub_s = 2'd1; e.pc_s = 1'b1; e.pc_en = model_cond(cc, psr);
            exp_q.push_back(e); n++;
        end else if (op == 4'd4 && ext == 4'd0) begin
            e.mem_s = 2'd0; exp_q.push_back(e);
            e.mem_reg_en = 1'b1; exp_q.push_back(e);
            exp_q.push_back(ex_wr(2'd2)); n += 3;
        end else if (op == 4'd4 && ext == 4'd4) begin
            e.mem_s = 2'd0; e.mem_we = 1'b1; exp_q.push_back(e); n++;
        end else if (op == 4'd4 && ext == 4'd12) begin
            e.pc_en = model_cond(cc, psr); exp_q.push_back(e); n++;
        end else if (op == 4'd4 && ext == 4'd8) begin
            e.alua_s = 2'd1; e.alub_s = 2'd3; e.alu_out_en = 1'b1; e.pc_en = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back(ex_wr(2'd3)); n += 2;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            e = '0; e.illegal_op = 1'b1;
            for (int i = 0; i < 21; i++) exp_q.push_back(e);
            n += 21;
`else
            exp_q.push_back(e); n++;
`endif
        end
        return n;
    endfunction

    // Single compare process: one expected vector per cycle while the queue is non-empty
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            req = cur;
            req.se_on = model_se(cur.se_on, OP_CODE);
            check("cycle_outputs", 32'(dut_vec()), 32'(req));
        end
    end

    task automatic check_zero(input string name);
        check(name, 32'(dut_vec()), 32'd0);
    endtask

    // Run one instruction starting at its FETCH edge; fields change after FETCH is sampled
    task automatic run_instr(input string name, input logic [3:0] op, input logic [3:0] ext,
                             input logic [3:0] cc, input logic [4:0] psr, input int cpi,
                             input bit fetch_after);
        int n;
        @(posedge clk);
        #1;
        check({name, "_fetch"}, {29'd0, (MEM_S == 2'd1), PC_EN, (ALUB_S == 2'd2)}, 32'd7);
        #1;
        OP_CODE = op; OP_EXT = ext; Rdest_addr = cc; PSR_OUT = psr;
        n = model_instr(op, ext, cc, psr);
        check({name, "_cpi"}, 32'(n), 32'(cpi));
        if (fetch_after) exp_q.push_back(ex_fetch());
        repeat (n - 1) @(posedge clk);
    endtask

    // Hold reset over two edges, release on a falling edge: one RST cycle, then FETCH
    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        check_zero("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("rst_cycle");
        exp_q.push_back(ex_fetch());
    endtask

    initial begin
        reset = 1'b0; OP_CODE = 4'd0; OP_EXT = 4'd0; Rdest_addr = 4'd0; PSR_OUT = 5'd0;
        #2 reset = 1'b1;
        #1 check_zero("rst_async");

        check("model_beq_z", 32'(model_cond(4'b0000, 5'b01000)), 32'd1);
        check("model_beq_nz", 32'(model_cond(4'b0000, 5'b00000)), 32'd0);
        check("model_nl", 32'(model_cond(4'b0101, 5'b00010)), 32'd0);

        release_reset();

        run_instr("add",    4'b0000, 4'b0101, 4'd3,    5'b00000, 5, 1'b1);
        run_instr("cmp",    4'b0000, 4'b1011, 4'd3,    5'b00000, 4, 1'b1);
        run_instr("addi",   4'b0101, 4'b0011, 4'd2,    5'b00000, 5, 1'b1);
        run_instr("andi",   4'b0001, 4'b1111, 4'd2,    5'b00000, 5, 1'b1);
        run_instr("cmpi",   4'b1011, 4'b0000, 4'd1,    5'b00000, 4, 1'b1);
        run_instr("movi",   4'b1101, 4'b0000, 4'd1,    5'b00000, 4, 1'b1);
        run_instr("load",   4'b0100, 4'b0000, 4'd4,    5'b00000, 6, 1'b1);
        run_instr("stor",   4'b0100, 4'b0100, 4'd4,    5'b00000, 4, 1'b1);
        run_instr("beq_t",  4'b1100, 4'b0000, 4'b0000, 5'b01000, 4, 1'b1);
        run_instr("beq_n",  4'b1100, 4'b0000, 4'b0000, 5'b00000, 4, 1'b1);
        run_instr("bcs_t",  4'b1100, 4'b0000, 4'b0010, 5'b00001, 4, 1'b1);
        run_instr("bpl_n",  4'b1100, 4'b0000, 4'b0111, 5'b10000, 4, 1'b1);
        run_instr("bal",    4'b1100, 4'b0000, 4'b1110, 5'b00000, 4, 1'b1);
        run_instr("bnv",    4'b1100, 4'b0000, 4'b1111, 5'b11111, 4, 1'b1);
        run_instr("b1010",  4'b1100, 4'b0000, 4'b1010, 5'b11111, 4, 1'b1);
        run_instr("jal_t",  4'b0100, 4'b1100, 4'b1110, 5'b00000, 4, 1'b1);
        run_instr("jnl_n",  4'b0100, 4'b1100, 4'b0101, 5'b00010, 4, 1'b1);

        // JAL, then reset asserted mid-WB must drop REG_WR at once
        run_instr("jal",    4'b0100, 4'b1000, 4'd5,    5'b00000, 5, 1'b0);
        #3 reset = 1'b1;
        #1 check_zero("rst_in_wb");
        release_reset();
        run_instr("add2",   4'b0000, 4'b0001, 4'd5,    5'b00000, 5, 1'b1);

`ifdef CTRL_ILLEGAL_TRAP_EN
        run_instr("ill_trap", 4'b1110, 4'b0000, 4'd0,  5'b00000, 24, 1'b0);
        #3 check("trap_flag", 32'(illegal_op), 32'd1);
        reset = 1'b1;
        #1 check_zero("rst_trap");
        release_reset();
`else
        run_instr("ill_1110", 4'b1110, 4'b0000, 4'd0,  5'b00000, 4, 1'b1);
        run_instr("ill_mem",  4'b0100, 4'b0010, 4'd0,  5'b00000, 4, 1'b1);
        run_instr("ill_0111", 4'b0111, 4'b0000, 4'd0,  5'b00000, 4, 1'b1);
`endif
        run_instr("sub_end", 4'b0000, 4'b1001, 4'd6,   5'b00000, 5, 1'b1);
        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the 16-bit CPU. It sits directly upstream of the datapath: it consumes the decoded instruction fields and `PSR_OUT` from the datapath and drives every datapath mux select, register enable and write strobe, plus the memory write enable. Outputs are Moore-decoded from the current state. Condition evaluation uses the `Rdest_addr` field as the condition code.

## Interface
- `REG_ADD`, default 4: width of the opcode, extension and condition fields.
- `PSRL`, default 5: PSR width. Bit layout is `[0]`C, `[1]`L, `[2]`F, `[3]`Z, `[4]`N.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high. Forces state RST and all outputs to 0 immediately.
- `OP_CODE`, `OP_EXT`, `Rdest_addr` in `REG_ADD`: instruction fields taken from the instruction register.
- `PSR_OUT` in `PSRL`: registered flags.
- `PC_S`, `MEM_DATA_S`, `INSTR_EN`, `ALU_OUT_EN`, `MEM_REG_EN`, `PC_EN`, `PSR_EN`, `SE_SIGN`, `REG_WR`, `MEM_WE` out 1: datapath and memory controls.
- `MEM_S`, `WD_S`, `ALUA_S`, `ALUB_S` out 2: mux selects.
  - `MEM_S`: 0 Rsrc, 1 PC.
  - `WD_S`: 0 IMM, 1 Rsrc, 2 MEM, 3 ALU_OUT.
  - `ALUA_S`: 0 Rsrc, 1 PC, 2 IMM.
  - `ALUB_S`: 0 Rdest, 1 IMM, 2 one, 3 zero.
- `illegal_op` out 1: sticky illegal-instruction flag.

## Operation
- **Defaults:** every output is 0 unless listed, except `MEM_S`=1. `SE_SIGN`=0 for opcodes 0001, 0010, 0011 and 1101; otherwise 1.
- **RST:** all outputs 0. Goes to FETCH.
- **FETCH:** `MEM_S`=1, `ALUA_S`=1, `ALUB_S`=2, `PC_S`=1, `PC_EN`=1, so PC←PC+1 (the datapath forces ADD whenever `PC_EN` is set). Goes to LATCH.
- **LATCH:** `INSTR_EN`=1; synchronous memory data is valid in this cycle. Goes to DECODE.
- **DECODE:** no outputs; Rsrc and Rdest are registered. Branches on `OP_CODE`/`OP_EXT`:
  - 0000 → EXEC_R.
  - 0001, 0010, 0011, 0101, 1001, 1011 → EXEC_I.
  - 1101 → MOVI.
  - 1100 → BR.
  - 0100 with ext 0000 → LD_ADDR; ext 0100 → ST; ext 1000 → JAL; ext 1100 → JMP.
  - Any other code → ILLEGAL.
- **EXEC_R:** `ALUA_S`=0, `ALUB_S`=0, `ALU_OUT_EN`=1, `PSR_EN`=1. Goes to WB, or to FETCH when `OP_EXT`=1011 (CMP).
- **EXEC_I:** `ALUA_S`=2, `ALUB_S`=0, `ALU_OUT_EN`=1, `PSR_EN`=1. Goes to WB, or to FETCH when `OP_CODE`=1011 (CMPI).
- **WB:** `WD_S`=3, `REG_WR`=1. Goes to FETCH.
- **MOVI:** `WD_S`=0, `REG_WR`=1. Goes to FETCH.
- **LD_ADDR:** `MEM_S`=0. Goes to LD_LATCH.
- **LD_LATCH:** `MEM_S`=0, `MEM_REG_EN`=1. Goes to LD_WB.
- **LD_WB:** `WD_S`=2, `REG_WR`=1. Goes to FETCH.
- **ST:** `MEM_S`=0, `MEM_DATA_S`=0, `MEM_WE`=1. Goes to FETCH.
- **BR:** `ALUA_S`=1, `ALUB_S`=1, `PC_S`=1, `PC_EN`=`cond_true`. Goes to FETCH.
- **JMP:** `PC_S`=0, `PC_EN`=`cond_true`. Goes to FETCH.
- **JAL:** `ALUA_S`=1, `ALUB_S`=3, `ALU_OUT_EN`=1, `PC_S`=0, `PC_EN`=1. The datapath captures PC+1 into ALU_OUT while the PC loads Rsrc. Goes to WB.
- **Condition codes** (`Rdest_addr`):
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C.
  - 0100 L; 0101 !L; 0110 N; 0111 !N.
  - 1110 always; 1111 never; all others never.
- **Reset mid-instruction:** the instruction is abandoned. No `REG_WR` or `MEM_WE` occurs after `reset` rises.

## Timing
- **Cycles per instruction, counted from FETCH:**
  - R-type, immediate ALU and JAL: 5.
  - CMP/CMPI, MOVI, ST, BR and JMP: 4.
  - LOAD: 6.
- **After reset release:** exactly one RST cycle, then FETCH.
- **Memory:** read latency is 1 cycle. The address is held for 2 cycles on LOAD.
- **Branch target:** BR/JMP conditions sample `PSR_OUT` during BR/JMP. A flag written in the preceding EXEC is visible.
- **Branch displacement:** relative to the already-incremented PC.

## Configuration
- **`CTRL_ILLEGAL_TRAP_EN` defined:** ILLEGAL sets `illegal_op`=1. The FSM stays in ILLEGAL with all other outputs 0 until reset.
- **Macro undefined:** ILLEGAL behaves as a one-cycle NOP that returns to FETCH. `illegal_op` is tied to 0.

## Structure
- **`ctrl_pkg`:** state enum, opcode/extension constants, mux-select constants, PSR bit indices, condition-code constants.
- **`cond_eval` sub-module:** combinational. Inputs are the condition code and PSR; output is `cond_true`.

## Test plan
- **Reset:** assert `reset` mid-cycle → all outputs 0 asynchronously. After release, 1 cycle of zeros, then `MEM_S`=1, `PC_EN`=1, `ALUB_S`=2.
- **ADD:** `OP_CODE`=0000, `OP_EXT`=0101 → cycle 4 has `ALU_OUT_EN`=`PSR_EN`=1 with A=Rsrc, B=Rdest. Cycle 5 has `REG_WR`=1, `WD_S`=3. Next FETCH at cycle 6.
- **LOAD:** 0100/0000 → `MEM_S`=0 in cycles 4–5, `MEM_REG_EN` in cycle 5, `REG_WR` with `WD_S`=2 in cycle 6.
- **BEQ:** 1100 with `Rdest_addr`=0000.
  - `PSR_OUT`=5'b01000 → BR has `PC_EN`=1, `PC_S`=1, `ALUA_S`=1, `ALUB_S`=1.
  - `PSR_OUT`=0 → `PC_EN`=0.
- **JAL then reset:** 0100/1000 → JAL cycle has `PC_EN`=1, `PC_S`=0, `ALUB_S`=3. Asserting `reset` during WB suppresses `REG_WR`.
- **Illegal opcode 1110:**
  - With the macro defined → `illegal_op`=1 and no further FETCH for 20 cycles.
  - Without the macro → FETCH follows 1 cycle after ILLEGAL.
